pb_dispatch_slot: RTL and testbench

//  Per-processing-block receiver for the GPU block-dispatch protocol. Accepts one

---
 rtl/pb_dispatch_slot.sv | 135 +++++++++++++
 tb/tb_pb_dispatch_slot.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_dispatch_slot.sv
// Per-processing-block dispatch slot: accepts one block index from the
// dispatcher, holds the processing_block in reset for a fixed launch window,
// counts run cycles until the block finishes or times out, and then reports
// the outcome over a valid/ready handshake.
module pb_dispatch_slot #(
   parameter int IDX_W      = 16,
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [IDX_W-1:0] disp_block_idx,
   input  logic [CNT_W-1:0] timeout_limit,
   output logic [IDX_W-1:0] pb_block_idx,
   output logic             pb_reset,
   input  logic             pb_finished,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [IDX_W-1:0] done_block_idx,
   output logic             done_timeout,
   output logic [CNT_W-1:0] run_cycles,
   output logic             busy
);

   localparam int LC_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] pb_block_idx_q, pb_block_idx_d;
   logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
   logic [LC_W-1:0]  launch_cnt_q, launch_cnt_d;
   logic             done_timeout_q, done_timeout_d;

   logic             accept;
   logic             launch_last;
   logic [CNT_W:0]   run_next_wide;
   logic             timeout_hit;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A block is taken only from IDLE and never while reset is asserted.
   assign accept      = (state_q == S_IDLE) && !reset && disp_valid;
   assign launch_last = (launch_cnt_q == LC_W'(1));

   // One extra bit keeps run_cycles+1 from wrapping onto a small limit.
   assign run_next_wide = {1'b0, run_cycles_q} + (CNT_W + 1)'(1);
   assign timeout_hit   = (timeout_limit != '0) &&
                          (run_next_wide == {1'b0, timeout_limit});

   // State register and datapath registers, all cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         pb_block_idx_q <= '0;
         run_cycles_q   <= '0;
         launch_cnt_q   <= '0;
         done_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pb_block_idx_q <= pb_block_idx_d;
         run_cycles_q   <= run_cycles_d;
         launch_cnt_q   <= launch_cnt_d;
         done_timeout_q <= done_timeout_d;
      end
   end

   // Next-state and datapath update; finish has priority over timeout.
   always_comb begin
      state_d        = state_q;
      pb_block_idx_d = pb_block_idx_q;
      run_cycles_d   = run_cycles_q;
      launch_cnt_d   = launch_cnt_q;
      done_timeout_d = done_timeout_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d        = S_LAUNCH;
               pb_block_idx_d = disp_block_idx;
               run_cycles_d   = '0;
               launch_cnt_d   = LC_W'(RST_CYCLES);
               done_timeout_d = 1'b0;
            end
         end
         S_LAUNCH: begin
            launch_cnt_d = launch_cnt_q - LC_W'(1);
            if (launch_last) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            run_cycles_d = sat_inc(run_cycles_q);
            if (pb_finished) begin
               state_d        = S_REPORT;
               done_timeout_d = 1'b0;
            end else if (timeout_hit) begin
               state_d        = S_REPORT;
               done_timeout_d = 1'b1;
            end
         end
         S_REPORT: begin
            if (done_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      disp_ready = (state_q == S_IDLE) && !reset;
      pb_reset   = reset || (state_q == S_LAUNCH);
      done_valid = (state_q == S_REPORT) && !reset;
      busy       = (state_q != S_IDLE);
   end

   assign pb_block_idx   = pb_block_idx_q;
   assign done_block_idx = pb_block_idx_q;
   assign done_timeout   = done_timeout_q;
   assign run_cycles     = run_cycles_q;

endmodule

// File: tb/tb_pb_dispatch_slot.sv
// Self-checking bench for pb_dispatch_slot: directed scenarios plus randomized
// dispatches, each compared against an outcome predicted from the protocol rules.
module tb_pb_dispatch_slot;

   localparam int IDX_W = 16;
   localparam int CNT_W = 16;
   localparam int RST   = 1;

   logic             clock;
   logic             reset;
   logic             disp_valid;
   logic             disp_ready;
   logic [IDX_W-1:0] disp_block_idx;
   logic [CNT_W-1:0] timeout_limit;
   logic [IDX_W-1:0] pb_block_idx;
   logic             pb_reset;
   logic             pb_finished;
   logic             done_valid;
   logic             done_ready;
   logic [IDX_W-1:0] done_block_idx;
   logic             done_timeout;
   logic [CNT_W-1:0] run_cycles;
   logic             busy;

   int n_vec = 0;
   int n_err = 0;

   // observed results of one dispatch
   int               lat;
   int               viol;
   logic             o_tmo;
   logic [IDX_W-1:0] o_idx;
   logic [CNT_W-1:0] o_cyc;

   pb_dispatch_slot #(.IDX_W(IDX_W), .CNT_W(CNT_W), .RST_CYCLES(RST)) dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_block_idx(disp_block_idx),
      .timeout_limit(timeout_limit),
      .pb_block_idx(pb_block_idx), .pb_reset(pb_reset), .pb_finished(pb_finished),
      .done_valid(done_valid), .done_ready(done_ready), .done_block_idx(done_block_idx),
      .done_timeout(done_timeout), .run_cycles(run_cycles), .busy(busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference: number of RUN cycles a block occupies (-1 = never ends).
   function automatic int exp_len(input int limit, input int fin_at);
      int e;
      e = (fin_at != 0) ? fin_at : -1;
      if (limit != 0 && (e < 0 || limit < e)) e = limit;
      return e;
   endfunction

   // Reference: report is a timeout only if the limit is reached strictly first.
   function automatic logic exp_tmo(input int limit, input int fin_at);
      return (limit != 0) && (fin_at == 0 || limit < fin_at);
   endfunction

   // Drives one block through the slot; records outcome and protocol violations.
   task automatic dispatch(input logic [IDX_W-1:0] idx, input int limit,
                           input int fin_at, input int bp, input int max_run);
      lat = -1; viol = 0; o_tmo = 1'bx; o_idx = 'x; o_cyc = 'x;
      @(negedge clock);
      disp_valid = 1'b1; disp_block_idx = idx; timeout_limit = CNT_W'(limit);
      pb_finished = 1'($urandom_range(0, 1)); done_ready = 1'($urandom_range(0, 1));
      #1;
      if (disp_ready !== 1'b1 || busy !== 1'b0) viol++;
      for (int r = 0; r < RST; r++) begin
         @(negedge clock);
         disp_valid = 1'($urandom_range(0, 1)); disp_block_idx = IDX_W'($urandom);
         pb_finished = 1'($urandom_range(0, 1)); done_ready = 1'b0;
         #1;
         if (pb_reset !== 1'b1 || disp_ready !== 1'b0 || done_valid !== 1'b0 ||
             pb_block_idx !== idx || run_cycles !== '0 || busy !== 1'b1) viol++;
      end
      disp_valid = 1'b0;
      for (int k = 1; ; k++) begin
         @(negedge clock);
         pb_finished = (fin_at != 0 && k >= fin_at);
         #1;
         if (done_valid === 1'b1) begin
            lat = k - 1;
            break;
         end
         if (pb_reset !== 1'b0 || disp_ready !== 1'b0 || busy !== 1'b1 ||
             run_cycles !== CNT_W'(k - 1)) viol++;
         if (k == max_run) return;
      end
      o_tmo = done_timeout; o_idx = done_block_idx; o_cyc = run_cycles;
      for (int b = 0; b < bp; b++) begin
         @(negedge clock);
         disp_valid = 1'($urandom_range(0, 1)); pb_finished = 1'($urandom_range(0, 1));
         timeout_limit = CNT_W'($urandom);
         #1;
         if (done_valid !== 1'b1 || done_block_idx !== o_idx || done_timeout !== o_tmo ||
             run_cycles !== o_cyc || disp_ready !== 1'b0) viol++;
      end
      @(negedge clock);
      done_ready = 1'b1; disp_valid = 1'($urandom_range(0, 1));
      #1;
      if (done_valid !== 1'b1 || disp_ready !== 1'b0) viol++;
      @(negedge clock);
      done_ready = 1'b0; disp_valid = 1'b0; pb_finished = 1'b0;
      #1;
      if (busy !== 1'b0 || disp_ready !== 1'b1 || done_valid !== 1'b0 ||
          run_cycles !== o_cyc || pb_reset !== 1'b0) viol++;
   endtask

   task automatic test_reset;
      reset = 1'b1; disp_valid = 1'b0; disp_block_idx = '0; timeout_limit = '0;
      pb_finished = 1'b0; done_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock); #1;
         n_vec++;
         if (pb_reset !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 || disp_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold cyc%0d got pb_reset=%b done_valid=%b busy=%b disp_ready=%b want 1 0 0 0",
                     c, pb_reset, done_valid, busy, disp_ready);
         end
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_vec++;
      if (disp_ready !== 1'b1 || pb_reset !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release got disp_ready=%b pb_reset=%b want 1 0", disp_ready, pb_reset);
      end
      n_vec++;
      if (run_cycles !== '0 || pb_block_idx !== '0 || done_block_idx !== '0 || done_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values got run=%0d pb_idx=%h done_idx=%h tmo=%b want 0 0 0 0",
                  run_cycles, pb_block_idx, done_block_idx, done_timeout);
      end
   endtask

   task automatic test_normal;
      dispatch(16'd5, 0, 10, 0, 200);
      n_vec++;
      if (lat !== 10 || o_idx !== 16'd5 || o_tmo !== 1'b0 || o_cyc !== 16'd10 || viol !== 0) begin
         n_err++;
         $display("FAIL normal got len=%0d idx=%h tmo=%b run=%0d viol=%0d want 10 0005 0 10 0",
                  lat, o_idx, o_tmo, o_cyc, viol);
      end
      dispatch(16'h1234, 0, 1, 0, 200);
      n_vec++;
      if (lat !== 1 || o_cyc !== 16'd1 || o_tmo !== 1'b0 || viol !== 0) begin
         n_err++;
         $display("FAIL finish_first got len=%0d run=%0d tmo=%b viol=%0d want 1 1 0 0", lat, o_cyc, o_tmo, viol);
      end
   endtask

   task automatic test_backpressure;
      dispatch(16'hA5C3, 0, 3, 4, 200);
      n_vec++;
      if (lat !== 3 || o_idx !== 16'hA5C3 || o_cyc !== 16'd3 || viol !== 0) begin
         n_err++;
         $display("FAIL backpressure got len=%0d idx=%h run=%0d viol=%0d want 3 a5c3 3 0", lat, o_idx, o_cyc, viol);
      end
   endtask

   task automatic test_timeout;
      dispatch(16'h0042, 8, 0, 0, 200);
      n_vec++;
      if (lat !== 8 || o_tmo !== 1'b1 || o_cyc !== 16'd8 || o_idx !== 16'h0042 || viol !== 0) begin
         n_err++;
         $display("FAIL timeout8 got len=%0d tmo=%b run=%0d idx=%h viol=%0d want 8 1 8 0042 0",
                  lat, o_tmo, o_cyc, o_idx, viol);
      end
      dispatch(16'h0077, 1, 0, 0, 200);
      n_vec++;
      if (lat !== 1 || o_tmo !== 1'b1 || o_cyc !== 16'd1 || viol !== 0) begin
         n_err++;
         $display("FAIL timeout1 got len=%0d tmo=%b run=%0d viol=%0d want 1 1 1 0", lat, o_tmo, o_cyc, viol);
      end
      dispatch(16'h0099, 0, 0, 0, 1000);
      n_vec++;
      if (lat !== -1 || viol !== 0 || busy !== 1'b1 || done_valid !== 1'b0 || run_cycles !== 16'd999) begin
         n_err++;
         $display("FAIL no_timeout got len=%0d viol=%0d busy=%b done_valid=%b run=%0d want -1 0 1 0 999",
                  lat, viol, busy, done_valid, run_cycles);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || disp_ready !== 1'b1) begin
         n_err++;
         $display("FAIL no_timeout_clear got busy=%b disp_ready=%b want 0 1", busy, disp_ready);
      end
   endtask

   task automatic test_tie;
      dispatch(16'h0006, 6, 6, 0, 200);
      n_vec++;
      if (lat !== 6 || o_tmo !== 1'b0 || o_cyc !== 16'd6 || viol !== 0) begin
         n_err++;
         $display("FAIL tie got len=%0d tmo=%b run=%0d viol=%0d want 6 0 6 0", lat, o_tmo, o_cyc, viol);
      end
   endtask

   task automatic test_abort;
      logic seen;
      // abort during RUN
      @(negedge clock);
      disp_valid = 1'b1; disp_block_idx = 16'h0BAD; timeout_limit = '0; pb_finished = 1'b0;
      @(negedge clock);
      disp_valid = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      n_vec++;
      if (pb_reset !== 1'b1 || done_valid !== 1'b0 || disp_ready !== 1'b0) begin
         n_err++;
         $display("FAIL abort_run_during got pb_reset=%b done_valid=%b disp_ready=%b want 1 0 0",
                  pb_reset, done_valid, disp_ready);
      end
      @(negedge clock); #1;
      n_vec++;
      if (busy !== 1'b0 || done_valid !== 1'b0 || pb_reset !== 1'b1) begin
         n_err++;
         $display("FAIL abort_run_after got busy=%b done_valid=%b pb_reset=%b want 0 0 1", busy, done_valid, pb_reset);
      end
      reset = 1'b0;
      // abort during REPORT
      @(negedge clock);
      disp_valid = 1'b1; disp_block_idx = 16'h0C0D; timeout_limit = 16'd2; done_ready = 1'b0;
      @(negedge clock);
      disp_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (done_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_vec++;
      if (seen !== 1'b1) begin
         n_err++;
         $display("FAIL abort_reach_report got done_valid_seen=%b want 1", seen);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (done_valid !== 1'b0 || pb_reset !== 1'b1) begin
         n_err++;
         $display("FAIL abort_report_during got done_valid=%b pb_reset=%b want 0 1", done_valid, pb_reset);
      end
      @(negedge clock); #1;
      n_vec++;
      if (busy !== 1'b0 || done_valid !== 1'b0) begin
         n_err++;
         $display("FAIL abort_report_after got busy=%b done_valid=%b want 0 0", busy, done_valid);
      end
      reset = 1'b0;
      dispatch(16'hFFFF, 0, 4, 1, 100);
      n_vec++;
      if (lat !== 4 || o_idx !== 16'hFFFF || o_tmo !== 1'b0 || o_cyc !== 16'd4 || viol !== 0) begin
         n_err++;
         $display("FAIL abort_recover got len=%0d idx=%h tmo=%b run=%0d viol=%0d want 4 ffff 0 4 0",
                  lat, o_idx, o_tmo, o_cyc, viol);
      end
   endtask

   task automatic test_random;
      int limit, fin_at, bp, e;
      logic [IDX_W-1:0] idx;
      logic et;
      for (int t = 0; t < 25; t++) begin
         idx    = IDX_W'($urandom);
         limit  = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
         fin_at = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
         if (limit == 0 && fin_at == 0) fin_at = $urandom_range(1, 20);
         bp = $urandom_range(0, 3);
         e  = exp_len(limit, fin_at);
         et = exp_tmo(limit, fin_at);
         dispatch(idx, limit, fin_at, bp, 100);
         n_vec++;
         if (lat !== e || o_idx !== idx || o_tmo !== et || o_cyc !== CNT_W'(e) || viol !== 0) begin
            n_err++;
            $display("FAIL random%0d lim=%0d fin=%0d got len=%0d idx=%h tmo=%b run=%0d viol=%0d want %0d %h %b %0d 0",
                     t, limit, fin_at, lat, o_idx, o_tmo, o_cyc, viol, e, idx, et, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_timeout();
      test_tie();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
